// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master wishbone arbiter.
// The optional ack watchdog is enabled with the ARB_TIMEOUT_EN macro.
`timescale 1ns/1ps
package wb_arb_pkg;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // State codes double as the one-hot grant seen on o_grant.
  typedef enum logic [1:0] {
    IDLE = GRANT_NONE,
    GNT0 = GRANT_M0,
    GNT1 = GRANT_M1
  } arb_state_e;

  localparam int DEF_MAX_OUTST = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_TIMEOUT   = 64;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int OUTST_W = cnt_w(DEF_MAX_OUTST);
  localparam int BURST_W = cnt_w(DEF_MAX_BURST);

endpackage

// File: rtl/wb_arb_outst.sv
// Up/down counter of accepted-but-unacked transactions with full/zero flags.
// Under ARB_TIMEOUT_EN a watchdog aborts the count when acks stop arriving.
`timescale 1ns/1ps
module wb_arb_outst
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTST = DEF_MAX_OUTST,
`ifdef ARB_TIMEOUT_EN
  parameter int TIMEOUT   = DEF_TIMEOUT,
`endif
  parameter int CNT_W     = cnt_w(DEF_MAX_OUTST)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic ack,
  output logic full,
  output logic zero,
  output logic next_zero,
  output logic timeout
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ack_valid;

  assign zero      = (count == '0);
  assign full      = (count == CNT_W'(MAX_OUTST));
  assign ack_valid = ack & ~zero;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (inc && !ack_valid)      count_next = count + CNT_W'(1);
    else if (!inc && ack_valid) count_next = count - CNT_W'(1);
    if (timeout)                count_next = '0;
  end

  assign next_zero = (count_next == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_next;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;

  assign timeout = ~zero & ~ack & (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wd <= '0;
    else if (zero || ack || timeout) wd <= '0;
    else                            wd <= wd + WD_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin two-master to one-slave pipelined wishbone arbiter (m0 = fetch, m1 = load/store).
// Optional ack watchdog under ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 3,
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int MAX_BURST = DEF_MAX_BURST
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_m0_wb_stb,
  input  logic              i_m1_wb_stb,
  input  logic              i_m0_wb_we,
  input  logic              i_m1_wb_we,
  input  logic [ADDR_W-1:0] i_m0_wb_addr,
  input  logic [ADDR_W-1:0] i_m1_wb_addr,
  input  logic [DATA_W-1:0] i_m0_wb_data,
  input  logic [DATA_W-1:0] i_m1_wb_data,
  input  logic [SEL_W-1:0]  i_m0_wb_sel,
  input  logic [SEL_W-1:0]  i_m1_wb_sel,
  output logic              o_m0_wb_ack,
  output logic              o_m1_wb_ack,
  output logic              o_m0_wb_stall,
  output logic              o_m1_wb_stall,
  output logic [DATA_W-1:0] o_m0_wb_data,
  output logic [DATA_W-1:0] o_m1_wb_data,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [SEL_W-1:0]  o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [1:0]        o_grant,
  output logic              o_timeout
);

  localparam int OUTST_CW = cnt_w(MAX_OUTST);
  localparam int BURST_CW = cnt_w(MAX_BURST);

  arb_state_e          state, state_next;
  logic [BURST_CW-1:0] burst, burst_next;
  logic                last_grant, last_grant_next;  // 1 = m1 held the bus last
  logic                own_stb, other_stb, burst_hit, block, accept, ack_route;
  logic                outst_full, outst_zero, outst_next_zero, timeout;

  wb_arb_outst #(
    .MAX_OUTST (MAX_OUTST),
`ifdef ARB_TIMEOUT_EN
    .TIMEOUT   (TIMEOUT),
`endif
    .CNT_W     (OUTST_CW)
  ) u_outst (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .inc       (accept),
    .ack       (i_wb_ack),
    .full      (outst_full),
    .zero      (outst_zero),
    .next_zero (outst_next_zero),
    .timeout   (timeout)
  );

  always_comb begin
    own_stb   = 1'b0;
    other_stb = 1'b0;
    unique case (state)
      GNT0:    begin own_stb = i_m0_wb_stb; other_stb = i_m1_wb_stb; end
      GNT1:    begin own_stb = i_m1_wb_stb; other_stb = i_m0_wb_stb; end
      default: ;
    endcase
  end

  assign burst_hit = (burst == BURST_CW'(MAX_BURST)) & other_stb;
  assign block     = outst_full | burst_hit;
  assign o_wb_stb  = own_stb & ~block;
  assign accept    = o_wb_stb & ~i_wb_stall;

  assign o_wb_we   = (state == GNT1) ? i_m1_wb_we   : i_m0_wb_we;
  assign o_wb_addr = (state == GNT1) ? i_m1_wb_addr : i_m0_wb_addr;
  assign o_wb_data = (state == GNT1) ? i_m1_wb_data : i_m0_wb_data;
  assign o_wb_sel  = (state == GNT1) ? i_m1_wb_sel  : i_m0_wb_sel;

  // Acks with nothing outstanding belong to no one and are dropped.
  assign ack_route     = i_wb_ack & ~outst_zero;
  assign o_m0_wb_ack   = ack_route & (state == GNT0);
  assign o_m1_wb_ack   = ack_route & (state == GNT1);
  assign o_m0_wb_stall = (state == GNT0) ? (i_wb_stall | block) : 1'b1;
  assign o_m1_wb_stall = (state == GNT1) ? (i_wb_stall | block) : 1'b1;
  assign o_m0_wb_data  = i_wb_data;
  assign o_m1_wb_data  = i_wb_data;
  assign o_grant       = state;
  assign o_timeout     = timeout;

  always_comb begin
    state_next      = state;
    burst_next      = burst;
    last_grant_next = last_grant;
    unique case (state)
      IDLE: begin
        if (i_m0_wb_stb && i_m1_wb_stb) state_next = last_grant ? GNT0 : GNT1;
        else if (i_m0_wb_stb)           state_next = GNT0;
        else if (i_m1_wb_stb)           state_next = GNT1;
      end
      GNT0, GNT1: begin
        if (accept && (burst != BURST_CW'(MAX_BURST))) burst_next = burst + BURST_CW'(1);
        // Hand over only once drained, so every ack maps to the current grant.
        if (outst_next_zero && (!own_stb || burst_hit)) begin
          last_grant_next = (state == GNT1);
          burst_next      = '0;
          if (other_stb) state_next = (state == GNT0) ? GNT1 : GNT0;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      burst      <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      burst      <= burst_next;
      last_grant <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2; the timeout scenario runs only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_wb_arbiter2;

  logic        clk;
  logic        i_reset_n;
  logic        i_m0_wb_stb, i_m1_wb_stb, i_m0_wb_we, i_m1_wb_we;
  logic [31:0] i_m0_wb_addr, i_m1_wb_addr, i_m0_wb_data, i_m1_wb_data;
  logic [2:0]  i_m0_wb_sel, i_m1_wb_sel;
  logic        o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_stall, o_m1_wb_stall;
  logic [31:0] o_m0_wb_data, o_m1_wb_data;
  logic        o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [2:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;
  logic [1:0]  o_grant;
  logic        o_timeout;

  logic auto_ack, ack_pipe, ack_man;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  wb_arbiter2 dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_m0_wb_stb(i_m0_wb_stb), .i_m1_wb_stb(i_m1_wb_stb),
    .i_m0_wb_we(i_m0_wb_we), .i_m1_wb_we(i_m1_wb_we),
    .i_m0_wb_addr(i_m0_wb_addr), .i_m1_wb_addr(i_m1_wb_addr),
    .i_m0_wb_data(i_m0_wb_data), .i_m1_wb_data(i_m1_wb_data),
    .i_m0_wb_sel(i_m0_wb_sel), .i_m1_wb_sel(i_m1_wb_sel),
    .o_m0_wb_ack(o_m0_wb_ack), .o_m1_wb_ack(o_m1_wb_ack),
    .o_m0_wb_stall(o_m0_wb_stall), .o_m1_wb_stall(o_m1_wb_stall),
    .o_m0_wb_data(o_m0_wb_data), .o_m1_wb_data(o_m1_wb_data),
    .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model for streaming tests: acks each accepted request one cycle later.
  always @(posedge clk) ack_pipe <= auto_ack & o_wb_stb & ~i_wb_stall;
  assign i_wb_ack = auto_ack ? ack_pipe : ack_man;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_m0_wb_stb = 0; i_m1_wb_stb = 0; i_m0_wb_we = 0; i_m1_wb_we = 0;
    i_m0_wb_addr = '0; i_m1_wb_addr = '0; i_m0_wb_data = '0; i_m1_wb_data = '0;
    i_m0_wb_sel = '0; i_m1_wb_sel = '0;
    i_wb_stall = 0; i_wb_data = '0; ack_man = 0; auto_ack = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    i_reset_n = 0;
    tick();
    tick();
    i_reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset_n = 0; i_m0_wb_stb = 1; i_m1_wb_stb = 1; i_wb_stall = 1; ack_man = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (o_grant !== 2'b00) begin err_cnt++; $display("FAIL rst_grant: got %b want 00", o_grant); end
      vec_cnt++; if ({o_m0_wb_stall, o_m1_wb_stall} !== 2'b11) begin err_cnt++; $display("FAIL rst_stall: got %b want 11", {o_m0_wb_stall, o_m1_wb_stall}); end
      vec_cnt++; if (o_wb_stb !== 1'b0) begin err_cnt++; $display("FAIL rst_wb_stb: got %b want 0", o_wb_stb); end
      vec_cnt++; if ({o_m0_wb_ack, o_m1_wb_ack, o_timeout} !== 3'b000) begin err_cnt++; $display("FAIL rst_ack_to: got %b want 000", {o_m0_wb_ack, o_m1_wb_ack, o_timeout}); end
    end
    ack_man = 0;
    i_reset_n = 1;
    #1;
    vec_cnt++; if (o_grant !== 2'b00) begin err_cnt++; $display("FAIL rst_release_grant: got %b want 00", o_grant); end
    tick();
    vec_cnt++; if (o_grant !== 2'b01) begin err_cnt++; $display("FAIL first_tie_grant: got %b want 01", o_grant); end
    vec_cnt++; if (o_wb_stb !== 1'b1) begin err_cnt++; $display("FAIL first_wb_stb: got %b want 1", o_wb_stb); end
    vec_cnt++; if ({o_m0_wb_stall, o_m1_wb_stall} !== 2'b11) begin err_cnt++; $display("FAIL first_stall: got %b want 11", {o_m0_wb_stall, o_m1_wb_stall}); end
    i_m0_wb_stb = 0; i_m1_wb_stb = 0; i_wb_stall = 0;
    tick();
    vec_cnt++; if (o_grant !== 2'b00) begin err_cnt++; $display("FAIL first_release: got %b want 00", o_grant); end
  endtask

  task automatic test_m0_reads();
    int          stb_v[7]  = '{1, 1, 1, 1, 0, 0, 0};
    int          ack_v[7]  = '{0, 0, 0, 1, 1, 1, 0};
    int          wstb_v[7] = '{0, 1, 1, 1, 0, 0, 0};
    int          cnt_v[7]  = '{0, 0, 1, 2, 2, 1, 0};
    int          stl_v[7]  = '{1, 0, 0, 0, 0, 0, 1};
    logic [1:0]  gnt_v[7]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [31:0] addr;
    logic [31:0] rdata;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      addr = 32'h1000 + 32'(((i > 0) ? i - 1 : 0) * 4);
      rdata = 32'hD000_0000 + 32'(i);
      i_m0_wb_stb = (stb_v[i] != 0); i_m0_wb_addr = addr;
      ack_man = (ack_v[i] != 0); i_wb_data = rdata;
      #1;
      vec_cnt++; if (o_wb_stb !== (wstb_v[i] != 0)) begin err_cnt++; $display("FAIL rd_wb_stb[%0d]: got %b want %0d", i, o_wb_stb, wstb_v[i]); end
      vec_cnt++; if (o_m0_wb_ack !== (ack_v[i] != 0)) begin err_cnt++; $display("FAIL rd_m0_ack[%0d]: got %b want %0d", i, o_m0_wb_ack, ack_v[i]); end
      vec_cnt++; if (o_m1_wb_ack !== 1'b0) begin err_cnt++; $display("FAIL rd_m1_ack[%0d]: got %b want 0", i, o_m1_wb_ack); end
      vec_cnt++; if (o_grant !== gnt_v[i]) begin err_cnt++; $display("FAIL rd_grant[%0d]: got %b want %b", i, o_grant, gnt_v[i]); end
      vec_cnt++; if (int'(dut.u_outst.count) !== cnt_v[i]) begin err_cnt++; $display("FAIL rd_outst[%0d]: got %0d want %0d", i, dut.u_outst.count, cnt_v[i]); end
      vec_cnt++; if (o_m0_wb_stall !== (stl_v[i] != 0)) begin err_cnt++; $display("FAIL rd_m0_stall[%0d]: got %b want %0d", i, o_m0_wb_stall, stl_v[i]); end
      if (wstb_v[i] != 0) begin
        vec_cnt++; if (o_wb_addr !== addr) begin err_cnt++; $display("FAIL rd_addr[%0d]: got %h want %h", i, o_wb_addr, addr); end
      end
      if (ack_v[i] != 0) begin
        vec_cnt++; if (o_m0_wb_data !== rdata) begin err_cnt++; $display("FAIL rd_data[%0d]: got %h want %h", i, o_m0_wb_data, rdata); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic       exp_s, exp_a;
    apply_reset();
    auto_ack = 1;
    i_m0_wb_stb = 1; i_m0_wb_addr = 32'h100;
    i_m1_wb_stb = 1; i_m1_wb_addr = 32'h200;
    #1;
    vec_cnt++; if ({o_grant, o_wb_stb} !== 3'b000) begin err_cnt++; $display("FAIL b2b_idle: got %b want 000", {o_grant, o_wb_stb}); end
    tick();
    for (int c = 1; c <= 27; c++) begin
      exp_g = ((((c - 1) / 9) % 2) == 0) ? 2'b01 : 2'b10;
      exp_s = (((c - 1) % 9) != 8);
      exp_a = (((c - 1) % 9) != 0);
      vec_cnt++; if (o_grant !== exp_g) begin err_cnt++; $display("FAIL b2b_grant[%0d]: got %b want %b", c, o_grant, exp_g); end
      vec_cnt++; if (o_wb_stb !== exp_s) begin err_cnt++; $display("FAIL b2b_wb_stb[%0d]: got %b want %b", c, o_wb_stb, exp_s); end
      if (exp_g == 2'b01) begin
        vec_cnt++; if ({o_m0_wb_ack, o_m1_wb_ack} !== {exp_a, 1'b0}) begin err_cnt++; $display("FAIL b2b_ack[%0d]: got %b want %b0", c, {o_m0_wb_ack, o_m1_wb_ack}, exp_a); end
      end else begin
        vec_cnt++; if ({o_m0_wb_ack, o_m1_wb_ack} !== {1'b0, exp_a}) begin err_cnt++; $display("FAIL b2b_ack[%0d]: got %b want 0%b", c, {o_m0_wb_ack, o_m1_wb_ack}, exp_a); end
      end
      if (exp_s) begin
        vec_cnt++; if (o_wb_addr !== ((exp_g == 2'b01) ? 32'h100 : 32'h200)) begin err_cnt++; $display("FAIL b2b_addr[%0d]: got %h", c, o_wb_addr); end
      end
      tick();
    end
    i_m0_wb_stb = 0; i_m1_wb_stb = 0;
    tick();
    vec_cnt++; if (o_grant !== 2'b00) begin err_cnt++; $display("FAIL b2b_end_grant: got %b want 00", o_grant); end
    auto_ack = 0;
  endtask

  task automatic test_stall();
    apply_reset();
    i_m1_wb_stb = 1; i_m1_wb_we = 1; i_m1_wb_addr = 32'h300; i_m1_wb_data = 32'h55AA; i_m1_wb_sel = 3'b101;
    tick();
    vec_cnt++; if (o_grant !== 2'b10) begin err_cnt++; $display("FAIL stl_grant: got %b want 10", o_grant); end
    vec_cnt++; if ({o_wb_we, o_wb_sel, o_wb_data} !== {1'b1, 3'b101, 32'h55AA}) begin err_cnt++; $display("FAIL stl_req_mux: got %b %b %h", o_wb_we, o_wb_sel, o_wb_data); end
    vec_cnt++; if ({o_m0_wb_stall, o_m1_wb_stall} !== 2'b10) begin err_cnt++; $display("FAIL stl_stall_pre: got %b want 10", {o_m0_wb_stall, o_m1_wb_stall}); end
    tick();
    i_wb_stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++; if ({o_m1_wb_stall, o_wb_stb} !== 2'b11) begin err_cnt++; $display("FAIL stl_hold[%0d]: got %b want 11", i, {o_m1_wb_stall, o_wb_stb}); end
      vec_cnt++; if (int'(dut.u_outst.count) !== 1) begin err_cnt++; $display("FAIL stl_outst[%0d]: got %0d want 1", i, dut.u_outst.count); end
      tick();
    end
    i_wb_stall = 0;
    #1;
    vec_cnt++; if (o_m1_wb_stall !== 1'b0) begin err_cnt++; $display("FAIL stl_drop: got %b want 0", o_m1_wb_stall); end
    tick();
    i_m1_wb_stb = 0; ack_man = 1;
    #1;
    vec_cnt++; if ({o_m0_wb_ack, o_m1_wb_ack, o_timeout} !== 3'b010) begin err_cnt++; $display("FAIL stl_ack1: got %b want 010", {o_m0_wb_ack, o_m1_wb_ack, o_timeout}); end
    vec_cnt++; if (int'(dut.u_outst.count) !== 2) begin err_cnt++; $display("FAIL stl_outst2: got %0d want 2", dut.u_outst.count); end
    tick();
    vec_cnt++; if (o_m1_wb_ack !== 1'b1) begin err_cnt++; $display("FAIL stl_ack2: got %b want 1", o_m1_wb_ack); end
    tick();
    ack_man = 0;
    #1;
    vec_cnt++; if ({o_grant, o_m1_wb_ack} !== 3'b000) begin err_cnt++; $display("FAIL stl_end: got %b want 000", {o_grant, o_m1_wb_ack}); end
  endtask

  task automatic test_max_outst();
    int         stb_v[15]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int         ack_v[15]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    int         cnt_v[15]  = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 4, 4, 3, 2, 1, 0};
    int         wstb_v[15] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int         stl_v[15]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1};
    logic [1:0] exp_g;
    apply_reset();
    i_m0_wb_stb = 1;
    tick();
    for (int i = 0; i < 15; i++) begin
      i_m0_wb_stb = (stb_v[i] != 0); ack_man = (ack_v[i] != 0);
      exp_g = (i < 14) ? 2'b01 : 2'b00;
      #1;
      vec_cnt++; if (int'(dut.u_outst.count) !== cnt_v[i]) begin err_cnt++; $display("FAIL mo_outst[%0d]: got %0d want %0d", i, dut.u_outst.count, cnt_v[i]); end
      vec_cnt++; if (o_wb_stb !== (wstb_v[i] != 0)) begin err_cnt++; $display("FAIL mo_wb_stb[%0d]: got %b want %0d", i, o_wb_stb, wstb_v[i]); end
      vec_cnt++; if (o_m0_wb_stall !== (stl_v[i] != 0)) begin err_cnt++; $display("FAIL mo_stall[%0d]: got %b want %0d", i, o_m0_wb_stall, stl_v[i]); end
      vec_cnt++; if (o_m0_wb_ack !== (ack_v[i] != 0)) begin err_cnt++; $display("FAIL mo_ack[%0d]: got %b want %0d", i, o_m0_wb_ack, ack_v[i]); end
      vec_cnt++; if ({o_grant, o_timeout} !== {exp_g, 1'b0}) begin err_cnt++; $display("FAIL mo_grant[%0d]: got %b want %b0", i, {o_grant, o_timeout}, exp_g); end
      tick();
    end
    ack_man = 0;
  endtask

  task automatic test_spurious();
    apply_reset();
    ack_man = 1;
    #1;
    vec_cnt++; if ({o_m0_wb_ack, o_m1_wb_ack} !== 2'b00) begin err_cnt++; $display("FAIL sp_idle_ack: got %b want 00", {o_m0_wb_ack, o_m1_wb_ack}); end
    tick();
    vec_cnt++; if (int'(dut.u_outst.count) !== 0) begin err_cnt++; $display("FAIL sp_idle_outst: got %0d want 0", dut.u_outst.count); end
    ack_man = 0; i_m0_wb_stb = 1;
    tick();
    tick();
    tick();
    vec_cnt++; if (int'(dut.u_outst.count) !== 2) begin err_cnt++; $display("FAIL sp_pre_rst_outst: got %0d want 2", dut.u_outst.count); end
    i_reset_n = 0;
    #1;
    vec_cnt++; if (int'(dut.u_outst.count) !== 0) begin err_cnt++; $display("FAIL sp_rst_outst: got %0d want 0", dut.u_outst.count); end
    vec_cnt++; if ({o_grant, o_wb_stb, o_m0_wb_stall} !== 4'b0001) begin err_cnt++; $display("FAIL sp_rst_out: got %b want 0001", {o_grant, o_wb_stb, o_m0_wb_stall}); end
    tick();
    i_reset_n = 1; i_m0_wb_stb = 0; ack_man = 1;
    #1;
    vec_cnt++; if (o_m0_wb_ack !== 1'b0) begin err_cnt++; $display("FAIL sp_lost_ack1: got %b want 0", o_m0_wb_ack); end
    tick();
    vec_cnt++; if ({o_grant, o_m0_wb_ack} !== 3'b000) begin err_cnt++; $display("FAIL sp_lost_ack2: got %b want 000", {o_grant, o_m0_wb_ack}); end
    ack_man = 0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    apply_reset();
    i_m0_wb_stb = 1;
    tick();
    tick();
    i_m0_wb_stb = 0;
    seen = 0;
    for (int n = 1; n <= 100 && seen == 0; n++) begin
      #1;
      if (o_timeout === 1'b1) seen = n;
      tick();
    end
    vec_cnt++; if (seen !== 64) begin err_cnt++; $display("FAIL to_cycle: got %0d want 64", seen); end
    vec_cnt++; if ({o_grant, o_timeout} !== 3'b000) begin err_cnt++; $display("FAIL to_release: got %b want 000", {o_grant, o_timeout}); end
    vec_cnt++; if (int'(dut.u_outst.count) !== 0) begin err_cnt++; $display("FAIL to_outst: got %0d want 0", dut.u_outst.count); end
    ack_man = 1;
    #1;
    vec_cnt++; if (o_m0_wb_ack !== 1'b0) begin err_cnt++; $display("FAIL to_late_ack: got %b want 0", o_m0_wb_ack); end
    tick();
    ack_man = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    i_reset_n = 0;
    test_reset();
    test_m0_reads();
    test_back_to_back();
    test_stall();
    test_max_outst();
    test_spurious();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
